emu_io_bridge: RTL

EMU_IO_BRIDGE -- requirements
Module: emu_io_bridge

---
 rtl/emu_io_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/emu_io_bridge.sv
// emu_io_bridge: board-side glue for an emulated design. It synchronises the
// asynchronous inputs, debounces the switches, and sequences lock/reset/run.
module emu_io_bridge #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SW_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYC     = 16,
  parameter int unsigned RST_HOLD    = 8,
  parameter logic [7:0]  OE_MASK     = 8'b1000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock_i,
  input  logic [SW_W-1:0]   switch_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        data_ctrl_i,
  input  logic [7:0]        uo_out_i,
  input  logic [7:0]        uio_out_i,
  input  logic [7:0]        uio_oe_i,
  output logic [DATA_W-1:0] ui_in_o,
  output logic [7:0]        uio_in_o,
  output logic [DATA_W-1:0] hash_o,
  output logic [1:0]        hash_ctrl_o,
  output logic              dut_rst_n_o,
  output logic              dut_ena_o,
  output logic              error_o,
  output logic [3:0]        led_o
);

  localparam int unsigned SYNC_W = 1 + SW_W + 3 + DATA_W;
  localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    HOLD,
    RUN,
    FAULT
  } state_t;

  state_t state, next_state;

  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0] sync_out;
  logic [DATA_W-1:0] data_s;
  logic [2:0]        ctrl_s;
  logic [SW_W-1:0]   sw_s;
  logic              lock_s;

  logic [DEB_W-1:0]  deb_cnt [SW_W];
  logic [SW_W-1:0]   sw_deb;
  logic [HOLD_W-1:0] hold_cnt;

  logic              rst_n_q, rst_n_d;
  logic              error_q, err_set;
  logic              run;
  logic [DATA_W-1:0] hash_q;
  logic [1:0]        hctrl_q;

  logic unused_uio_bits;
  assign unused_uio_bits = ^{uio_out_i[6:4], uio_out_i[2:0]};

  // All asynchronous inputs share one synchroniser bank of equal depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pll_lock_i, switch_i, data_ctrl_i, data_i};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign data_s   = sync_out[DATA_W-1:0];
  assign ctrl_s   = sync_out[DATA_W +: 3];
  assign sw_s     = sync_out[DATA_W+3 +: SW_W];
  assign lock_s   = sync_out[SYNC_W-1];

  // A switch level is accepted only after it differs from the debounced
  // value for DEB_CYC consecutive cycles; any return clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_deb <= '0;
      for (int unsigned i = 0; i < SW_W; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SW_W; i++) begin
        if (sw_s[i] == sw_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          sw_deb[i]  <= sw_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (sw_deb[0]) next_state = WAIT_LOCK;
      WAIT_LOCK, HOLD, RUN: begin
        if (!lock_s)                                    next_state = WAIT_LOCK;
        else if (!sw_deb[0])                            next_state = IDLE;
        else if (state == WAIT_LOCK)                    next_state = HOLD;
        else if (state == HOLD && hold_cnt == HOLD_LAST) next_state = RUN;
        else if (state == RUN && uio_oe_i != OE_MASK)   next_state = FAULT;
      end
      FAULT: if (!sw_deb[0]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                     hold_cnt <= '0;
    else if (state == WAIT_LOCK) hold_cnt <= '0;
    else if (state == HOLD)      hold_cnt <= hold_cnt + 1'b1;
  end

  // The reset register follows next_state so it tracks the state exactly.
  always_comb begin
    run         = (state == RUN);
    rst_n_d     = (next_state == RUN) || (next_state == FAULT);
    err_set     = run && (uio_oe_i != OE_MASK);
    dut_ena_o   = run & ~sw_deb[1];
    hash_o      = run ? hash_q : '0;
    hash_ctrl_o = run ? hctrl_q : '0;
    led_o       = {error_q, run, lock_s, sw_deb[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_n_q <= 1'b0;
      error_q <= 1'b0;
      hash_q  <= '0;
      hctrl_q <= '0;
    end else begin
      rst_n_q <= rst_n_d;
      if (err_set) error_q <= 1'b1;
      hash_q  <= DATA_W'(uo_out_i);
      hctrl_q <= {uio_out_i[7], uio_out_i[3]};
    end
  end

  assign ui_in_o     = data_s;
  assign uio_in_o    = {5'b0, ctrl_s};
  assign dut_rst_n_o = rst_n_q;
  assign error_o     = error_q;

endmodule
